// File: rtl/larpix_pkt_pkg.sv
// Packet layout, declare codes and parity helper shared by the config packet path.
// Every field position used by the checker and the reply builder lives here.
package larpix_pkt_pkg;

   typedef enum logic [1:0] {
      DATA      = 2'd1,
      CFG_WRITE = 2'd2,
      CFG_READ  = 2'd3
   } pkt_decl_e;

   localparam int DECL_LSB   = 0;
   localparam int DECL_MSB   = 1;
   localparam int ID_LSB     = 2;
   localparam int ID_MSB     = 9;
   localparam int ADDR_LSB   = 10;
   localparam int ADDR_MSB   = 17;
   localparam int DATA_LSB   = 18;
   localparam int DATA_MSB   = 25;
   localparam int MAGIC_LSB  = 26;
   localparam int MAGIC_MSB  = 57;
   localparam int FLAGS_LSB  = 58;
   localparam int FLAGS_MSB  = 61;
   localparam int DOWN_BIT   = 62;
   localparam int PARITY_BIT = 63;

   localparam logic [31:0] PKT_MAGIC = 32'h8950_4E47;

   // Parity bit value that makes the full 64-bit word odd.
   function automatic logic odd_parity(input logic [62:0] body);
      return ~^body;
   endfunction

endpackage

// File: rtl/larpix_config_responder_if.sv
// UART rx/tx and register-map handshake between the responder and the chip fabric.
// The responder takes the master side: it drives every strobe.
interface larpix_config_responder_if #(
   parameter int WIDTH = 64
);
   logic [WIDTH-1:0] rx_data;
   logic             rx_empty;
   logic             uld_rx_data;
   logic             cfg_we;
   logic             cfg_re;
   logic [7:0]       cfg_addr;
   logic [7:0]       cfg_wdata;
   logic [7:0]       cfg_rdata;
   logic [3:0]       fifo_flags;
   logic [WIDTH-1:0] tx_data;
   logic             ld_tx_data;
   logic             tx_busy;

   modport master (
      input  rx_data, rx_empty, cfg_rdata, fifo_flags, tx_busy,
      output uld_rx_data, cfg_we, cfg_re, cfg_addr, cfg_wdata, tx_data, ld_tx_data
   );

   modport slave (
      output rx_data, rx_empty, cfg_rdata, fifo_flags, tx_busy,
      input  uld_rx_data, cfg_we, cfg_re, cfg_addr, cfg_wdata, tx_data, ld_tx_data
   );
endinterface

// File: rtl/larpix_pkt_check.sv
// Combinational decode of a latched packet: parity, magic, chip-ID match and declare type.
module larpix_pkt_check
   import larpix_pkt_pkg::*;
#(
   parameter int          WIDTH     = 64,
   parameter logic [31:0] MAGIC     = PKT_MAGIC,
   parameter logic [7:0]  GLOBAL_ID = 8'hFF
) (
   input  logic [WIDTH-1:0] pkt,
   input  logic [7:0]       chip_id,
   output logic             parity_ok,
   output logic             magic_ok,
   output logic             id_match,
   output logic             is_write,
   output logic             is_read
);
   logic [7:0] id;
   logic [1:0] decl;

   assign id        = pkt[ID_MSB:ID_LSB];
   assign decl      = pkt[DECL_MSB:DECL_LSB];
   assign parity_ok = pkt[PARITY_BIT] == odd_parity(pkt[PARITY_BIT-1:0]);
   assign magic_ok  = pkt[MAGIC_MSB:MAGIC_LSB] == MAGIC;
   assign id_match  = (id == chip_id) || (id == GLOBAL_ID);
   assign is_write  = decl == CFG_WRITE;
   assign is_read   = decl == CFG_READ;
endmodule

// File: rtl/larpix_config_responder.sv
// Chip-side config packet engine: unloads rx words, validates them, performs register
// writes, and answers reads with a reply packet loaded into the transmitter.
module larpix_config_responder
   import larpix_pkt_pkg::*;
#(
   parameter int          WIDTH     = 64,
   parameter logic [31:0] MAGIC     = PKT_MAGIC,
   parameter logic [7:0]  GLOBAL_ID = 8'hFF,
   parameter int          CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [7:0]           chip_id,
   larpix_config_responder_if.master bus,
   output logic [CNT_W-1:0]     pkt_cnt,
   output logic [CNT_W-1:0]     parity_err_cnt,
   output logic [CNT_W-1:0]     magic_err_cnt
);
   typedef enum logic [2:0] {
      IDLE, UNLOAD, CHECK, WRITE, READ_REQ, READ_CAP, SEND, GUARD
   } state_e;

   state_e           state;
   logic [WIDTH-1:0] pkt_r, reply_r, tx_data_r;
   logic             uld_r, we_r, re_r, ld_r;
   logic [7:0]       addr_r, wdata_r;
   logic             parity_ok, magic_ok, id_match, is_write, is_read;
   logic [62:0]      reply_body;

   larpix_pkt_check #(
      .WIDTH(WIDTH), .MAGIC(MAGIC), .GLOBAL_ID(GLOBAL_ID)
   ) u_check (
      .pkt(pkt_r), .chip_id(chip_id), .parity_ok(parity_ok), .magic_ok(magic_ok),
      .id_match(id_match), .is_write(is_write), .is_read(is_read)
   );

   // Reply always carries our own ID, even when answering a broadcast.
   assign reply_body = {1'b1, bus.fifo_flags, MAGIC, bus.cfg_rdata, addr_r, chip_id, CFG_READ};

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   assign bus.uld_rx_data = uld_r;
   assign bus.cfg_we      = we_r;
   assign bus.cfg_re      = re_r;
   assign bus.cfg_addr    = addr_r;
   assign bus.cfg_wdata   = wdata_r;
   assign bus.tx_data     = tx_data_r;
   assign bus.ld_tx_data  = ld_r;

   // Strobes are registered on entry to their state, so each is high exactly one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         pkt_r          <= '0;
         reply_r        <= '0;
         tx_data_r      <= '0;
         uld_r          <= 1'b0;
         we_r           <= 1'b0;
         re_r           <= 1'b0;
         ld_r           <= 1'b0;
         addr_r         <= '0;
         wdata_r        <= '0;
         pkt_cnt        <= '0;
         parity_err_cnt <= '0;
         magic_err_cnt  <= '0;
      end else begin
         uld_r <= 1'b0;
         we_r  <= 1'b0;
         re_r  <= 1'b0;
         ld_r  <= 1'b0;
         case (state)
            IDLE: if (!bus.rx_empty) begin
               uld_r <= 1'b1;
               state <= UNLOAD;
            end
            UNLOAD: begin
               pkt_r <= bus.rx_data;
               state <= CHECK;
            end
            CHECK: begin
               state <= IDLE;
               if (!parity_ok)
                  parity_err_cnt <= sat_inc(parity_err_cnt);
               else if (!(is_write || is_read)) begin
                  // DATA and undefined declares are not ours to answer.
               end else if (!magic_ok)
                  magic_err_cnt <= sat_inc(magic_err_cnt);
               else if (id_match) begin
                  pkt_cnt <= sat_inc(pkt_cnt);
                  addr_r  <= pkt_r[ADDR_MSB:ADDR_LSB];
                  if (is_write) begin
                     we_r    <= 1'b1;
                     wdata_r <= pkt_r[DATA_MSB:DATA_LSB];
                     state   <= WRITE;
                  end else begin
                     re_r  <= 1'b1;
                     state <= READ_REQ;
                  end
               end
            end
            WRITE:    state <= IDLE;
            READ_REQ: state <= READ_CAP;
            READ_CAP: begin
               reply_r <= {odd_parity(reply_body), reply_body};
               state   <= SEND;
            end
            SEND: if (!bus.tx_busy) begin
               tx_data_r <= reply_r;
               ld_r      <= 1'b1;
               state     <= GUARD;
            end
            GUARD:    state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_larpix_config_responder.sv
// Randomised scoreboard bench: a packet-level reference model predicts register writes,
// reply words and counters; a negedge monitor compares whatever the responder emits.
module tb_larpix_config_responder;
   localparam logic [31:0] MAGIC = 32'h8950_4E47;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] chip_id;
   logic [7:0] pkt_cnt, parity_err_cnt, magic_err_cnt;

   larpix_config_responder_if #(.WIDTH(64)) dif ();

   larpix_config_responder #(
      .WIDTH(64), .MAGIC(MAGIC), .GLOBAL_ID(8'hFF), .CNT_W(8)
   ) dut (
      .clk(clk), .reset_n(reset_n), .chip_id(chip_id), .bus(dif),
      .pkt_cnt(pkt_cnt), .parity_err_cnt(parity_err_cnt), .magic_err_cnt(magic_err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rd;
      logic [7:0]  addr;
      logic [7:0]  data;
      logic [63:0] word;
   } exp_t;

   exp_t        exp_q[$];
   logic [63:0] rx_q[$];
   logic [7:0]  rmap[256];
   logic [7:0]  mmem[256];
   int errs = 0, checks = 0;
   int m_pkt = 0, m_par = 0, m_mag = 0;
   int cyc = 0, uld_cnt = 0, ld_cnt = 0, we_cnt = 0, re_cnt = 0;
   int last_uld_cyc = 0, last_ld_cyc = 0;
   bit pop_pend = 0, re_seen = 0, busy_force = 0, busy_rand = 0;
   logic [7:0] re_addr = 8'h00;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, got, want);
      end
   endtask

   function automatic logic [63:0] mk(input logic [1:0] decl, input logic [7:0] id,
                                      input logic [7:0] addr, input logic [7:0] data,
                                      input logic [31:0] mg, input bit badpar);
      logic [62:0] b;
      b = {5'b0, mg, data, addr, id, decl};
      return {(~^b) ^ badpar, b};
   endfunction

   // Packet-level reference: decides fate of a packet from the field rules alone.
   function automatic void model(input logic [63:0] p);
      exp_t e;
      logic [7:0] a;
      if (^p !== 1'b1) begin
         if (m_par < 255) m_par++;
         return;
      end
      if (p[1:0] < 2'd2) return;
      if (p[57:26] != MAGIC) begin
         if (m_mag < 255) m_mag++;
         return;
      end
      if (p[9:2] != chip_id && p[9:2] != 8'hFF) return;
      if (m_pkt < 255) m_pkt++;
      a      = p[17:10];
      e.addr = a;
      e.rd   = (p[1:0] == 2'd3);
      if (!e.rd) begin
         e.data  = p[25:18];
         mmem[a] = e.data;
         e.word  = '0;
      end else begin
         e.data = mmem[a];
         e.word = {1'b0, 1'b1, dif.fifo_flags, MAGIC, e.data, a, chip_id, 2'b11};
         e.word[63] = ~^e.word[62:0];
      end
      exp_q.push_back(e);
   endfunction

   task automatic send(input logic [63:0] p);
      model(p);
      rx_q.push_back(p);
   endtask

   task automatic chk_cnt(input string nm);
      chk({nm, "_pkt_cnt"}, pkt_cnt, 64'(m_pkt));
      chk({nm, "_parity_err_cnt"}, parity_err_cnt, 64'(m_par));
      chk({nm, "_magic_err_cnt"}, magic_err_cnt, 64'(m_mag));
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while ((rx_q.size() != 0 || exp_q.size() != 0) && n < 6000) begin
         @(negedge clk);
         n++;
      end
      repeat (8) @(negedge clk);
      chk({nm, "_drain_timeout"}, 64'(n >= 6000), 0);
   endtask

   task automatic wait_uld(input string nm);
      int n;
      n = 0;
      while (!dif.uld_rx_data && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 64'(n >= 1000), 0);
   endtask

   // Environment (UART rx, register map, transmitter) plus the scoreboard monitor.
   always @(negedge clk) begin : env
      exp_t e;
      cyc++;
      if (reset_n) begin
         if (dif.uld_rx_data) begin
            uld_cnt++;
            last_uld_cyc = cyc;
         end
         if (dif.cfg_we) begin
            we_cnt++;
            rmap[dif.cfg_addr] = dif.cfg_wdata;
            if (exp_q.size() == 0 || exp_q[0].rd) chk("unexpected_cfg_we", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("we_addr", dif.cfg_addr, e.addr);
               chk("we_data", dif.cfg_wdata, e.data);
            end
         end
         if (dif.cfg_re) begin
            re_cnt++;
            if (exp_q.size() == 0 || !exp_q[0].rd) chk("unexpected_cfg_re", 1, 0);
            else chk("re_addr", dif.cfg_addr, exp_q[0].addr);
         end
         if (dif.ld_tx_data) begin
            ld_cnt++;
            last_ld_cyc = cyc;
            chk("ld_while_busy", dif.tx_busy, 0);
            chk("reply_odd_parity", ^dif.tx_data, 1);
            if (exp_q.size() == 0 || !exp_q[0].rd) chk("unexpected_ld", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("reply_word", dif.tx_data, e.word);
            end
         end
      end
      if (pop_pend) begin
         void'(rx_q.pop_front());
         pop_pend = 0;
      end
      if (dif.uld_rx_data && reset_n) pop_pend = 1;
      dif.rx_empty = (rx_q.size() == (pop_pend ? 1 : 0));
      dif.rx_data  = (rx_q.size() != 0) ? rx_q[0] : {$urandom, $urandom};
      dif.cfg_rdata = re_seen ? rmap[re_addr] : 8'($urandom);
      re_seen = dif.cfg_re && reset_n;
      re_addr = dif.cfg_addr;
      dif.tx_busy = busy_force || (busy_rand && $urandom_range(0, 2) == 0);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int k, u0, l0, w0, r0;
      logic [63:0] p;
      dif.rx_empty = 1'b1;
      dif.rx_data = '0;
      dif.cfg_rdata = '0;
      dif.fifo_flags = '0;
      dif.tx_busy = 1'b0;
      chip_id = 8'h10;
      for (int i = 0; i < 256; i++) begin
         rmap[i] = 8'($urandom);
         mmem[i] = rmap[i];
      end
      repeat (3) @(negedge clk);
      chk("rst_uld", dif.uld_rx_data, 0);
      chk("rst_we", dif.cfg_we, 0);
      chk("rst_re", dif.cfg_re, 0);
      chk("rst_ld", dif.ld_tx_data, 0);
      chk("rst_tx_data", dif.tx_data, 0);
      chk("rst_addr", dif.cfg_addr, 0);
      chk("rst_wdata", dif.cfg_wdata, 0);
      chk_cnt("rst");
      reset_n = 1'b1;
      @(negedge clk);

      // Write to own ID
      send(mk(2'd2, 8'h10, 8'h20, 8'hA5, MAGIC, 0));
      drain("wr");
      chk("wr_pkt_cnt", pkt_cnt, 1);
      chk("wr_regmap", rmap[8'h20], 8'hA5);
      chk("wr_we_pulses", 64'(we_cnt), 1);
      chk("wr_no_ld", 64'(ld_cnt), 0);

      // Read with exact load latency
      rmap[8'h20] = 8'h3C;
      mmem[8'h20] = 8'h3C;
      dif.fifo_flags = 4'b0101;
      send(mk(2'd3, 8'h10, 8'h20, 8'h00, MAGIC, 0));
      wait_uld("rd_uld_timeout");
      k = 0;
      while (!dif.ld_tx_data && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("rd_uld_to_ld_latency", 64'(k), 5);
      drain("rd");
      chk("rd_decl", dif.tx_data[1:0], 2'd3);
      chk("rd_chip_id", dif.tx_data[9:2], 8'h10);
      chk("rd_addr", dif.tx_data[17:10], 8'h20);
      chk("rd_data", dif.tx_data[25:18], 8'h3C);
      chk("rd_flags", dif.tx_data[61:58], 4'b0101);
      chk("rd_downstream", dif.tx_data[62], 1);
      chk("rd_ld_pulses", 64'(ld_cnt), 1);

      // Broadcast read answered with own ID
      chip_id = 8'h1F;
      send(mk(2'd3, 8'hFF, 8'h07, 8'h00, MAGIC, 0));
      drain("bc");
      chk("bc_chip_id", dif.tx_data[9:2], 8'h1F);
      chk_cnt("bc");

      // Packets for another chip, bad parity, bad magic, data declares
      w0 = we_cnt; l0 = ld_cnt; r0 = re_cnt;
      send(mk(2'd2, 8'h05, 8'h11, 8'h22, MAGIC, 0));
      send(mk(2'd3, 8'h05, 8'h11, 8'h00, MAGIC, 0));
      drain("other");
      chk_cnt("other");
      p = mk(2'd2, 8'h1F, 8'h12, 8'h34, MAGIC, 0);
      p[63] = ~p[63];
      send(p);
      drain("par");
      chk("par_cnt", parity_err_cnt, 1);
      send(mk(2'd3, 8'h1F, 8'h12, 8'h00, 32'hDEADBEEF, 0));
      drain("mag");
      chk("mag_cnt", magic_err_cnt, 1);
      send(mk(2'd1, 8'h1F, 8'h13, 8'h77, MAGIC, 0));
      send(mk(2'd0, 8'h1F, 8'h14, 8'h78, MAGIC, 0));
      drain("decl");
      chk_cnt("drops");
      chk("drops_no_we", 64'(we_cnt - w0), 0);
      chk("drops_no_re", 64'(re_cnt - r0), 0);
      chk("drops_no_ld", 64'(ld_cnt - l0), 0);

      // Transmitter back-pressure with a second word queued
      busy_force = 1;
      u0 = uld_cnt; l0 = ld_cnt;
      send(mk(2'd3, 8'h1F, 8'h33, 8'h00, MAGIC, 0));
      send(mk(2'd2, 8'h1F, 8'h44, 8'h5A, MAGIC, 0));
      repeat (200) @(negedge clk);
      chk("bp_single_unload", 64'(uld_cnt - u0), 1);
      chk("bp_no_ld_while_busy", 64'(ld_cnt - l0), 0);
      busy_force = 0;
      drain("bp");
      chk("bp_two_unloads", 64'(uld_cnt - u0), 2);
      chk("bp_second_unload_after_guard", 64'(last_uld_cyc - last_ld_cyc >= 2), 1);
      chk("bp_regmap", rmap[8'h44], 8'h5A);
      chk_cnt("bp");

      // Reset in the read-capture cycle
      l0 = ld_cnt; w0 = we_cnt;
      send(mk(2'd3, 8'h1F, 8'h55, 8'h00, MAGIC, 0));
      wait_uld("rs_uld_timeout");
      repeat (3) @(negedge clk);
      #1 reset_n = 1'b0;
      #1;
      chk("rs_uld", dif.uld_rx_data, 0);
      chk("rs_we", dif.cfg_we, 0);
      chk("rs_re", dif.cfg_re, 0);
      chk("rs_ld", dif.ld_tx_data, 0);
      chk("rs_tx_data", dif.tx_data, 0);
      chk("rs_addr", dif.cfg_addr, 0);
      exp_q.delete();
      m_pkt = 0; m_par = 0; m_mag = 0;
      chk_cnt("rs");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("rs_no_late_ld", 64'(ld_cnt - l0), 0);
      chk("rs_no_late_we", 64'(we_cnt - w0), 0);

      // Randomised traffic with a jittery transmitter
      busy_rand = 1;
      for (int b = 0; b < 6; b++) begin
         chip_id = 8'($urandom_range(0, 254));
         dif.fifo_flags = 4'($urandom);
         for (int i = 0; i < 12; i++) begin
            logic [7:0]  id;
            logic [31:0] mg;
            bit          bp;
            case ($urandom_range(0, 3))
               0:       id = 8'hFF;
               1:       id = 8'($urandom);
               default: id = chip_id;
            endcase
            mg = ($urandom_range(0, 5) == 0) ? $urandom : MAGIC;
            bp = ($urandom_range(0, 7) == 0);
            send(mk(2'($urandom), id, 8'($urandom), 8'($urandom), mg, bp));
         end
         drain("rnd");
         chk_cnt("rnd");
      end
      busy_rand = 0;

      // Parity error counter saturation
      for (int i = 0; i < 300; i++)
         send(mk(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), MAGIC, 1));
      drain("sat");
      chk("sat_parity_err_cnt", parity_err_cnt, 255);
      chk_cnt("sat");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
